// File: rtl/fip_pkg.sv
// Package: fip_pkg
// Shared fixed-point definitions for the sequential fip units.
// Default format is Q16.16 (16 integer bits including sign, 16 fractional bits).
package fip_pkg;

  // Default format; units take these as parameter defaults.
  localparam int FIP_INT_BITS  = 16;
  localparam int FIP_FRAC_BITS = 16;
  localparam int FIP_W         = FIP_INT_BITS + FIP_FRAC_BITS;

  // Signed fixed-point word in the default format.
  typedef logic signed [FIP_W-1:0] fip_t;

  // Saturation limits of the default format.
  localparam fip_t FIP_MAX = {1'b0, {(FIP_W-1){1'b1}}};
  localparam fip_t FIP_MIN = {1'b1, {(FIP_W-1){1'b0}}};

  // Handshake-level state shared by the multi-cycle fip units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fip_div_state_e;

endpackage

// File: rtl/fip_div_step.sv
// Module: fip_div_step
// One combinational radix-2 restoring division iteration.
// The remainder entering a step is always below the divisor magnitude, so
// after shifting in the next numerator bit it still fits in W+1 bits.
module fip_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         num_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // Shift in the next numerator bit; subtract the divisor when it fits.
  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    shifted = {rem_in, num_bit};
    diff    = shifted - (W+2)'(divisor);
    q_bit   = (shifted >= (W+2)'(divisor));
    rem_out = (W+1)'(q_bit ? diff : shifted);
  end

endmodule

// File: rtl/fip_seq_div.sv
// Module: fip_seq_div
// Sequential signed fixed-point divider, Q INT_BITS.FRAC_BITS, radix-2
// restoring, one quotient bit per cycle, valid/ready on both sides.
// Overflowing results saturate to the format limits; a zero divisor
// completes in one cycle with div_by_zero set.
// Optional build macro FIP_DIV_ROUND_EN: one extra guard iteration and
// round-half-away-from-zero of the magnitude (latency +1 cycle).
module fip_seq_div
  import fip_pkg::*;
#(
  parameter int INT_BITS  = FIP_INT_BITS,
  parameter int FRAC_BITS = FIP_FRAC_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0] dividend,
  input  logic [INT_BITS+FRAC_BITS-1:0] divisor,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] quotient,
  output logic                          div_by_zero,
  output logic                          overflow
);

  localparam int W = INT_BITS + FRAC_BITS;
`ifdef FIP_DIV_ROUND_EN
  localparam int ROUND = 1;
`else
  localparam int ROUND = 0;
`endif
  // Numerator is |dividend| << FRAC_BITS, plus one guard bit when rounding.
  localparam int ITER  = W + FRAC_BITS + ROUND;
  localparam int CNT_W = $clog2(ITER);
  // Magnitude width leaves headroom for the rounding increment.
  localparam int MAG_W = W + FRAC_BITS + 1;

  localparam logic [W-1:0]     Q_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     Q_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [MAG_W-1:0] POS_LIM  = MAG_W'(Q_MAX);
  localparam logic [MAG_W-1:0] NEG_LIM  = MAG_W'(Q_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  fip_div_state_e   state;
  logic [CNT_W-1:0] counter;

  // Numerator bits leave at the MSB while quotient bits enter at the LSB,
  // so after ITER steps this register holds the raw quotient.
  logic [ITER-1:0]  work;
  logic [W:0]       rem;
  logic [W-1:0]     dvs_mag;
  logic             neg;

  logic             accept;
  logic [W-1:0]     dvd_mag_in;
  logic [W-1:0]     dvs_mag_in;

  logic             step_q;
  logic [W:0]       step_rem;

  logic [ITER-1:0]  raw_q;
  logic [MAG_W-1:0] mag;
  logic [W-1:0]     calc_q;
  logic             calc_ovf;

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  // |MIN| = 2^(W-1) is representable as a W-bit unsigned magnitude.
  assign dvd_mag_in = dividend[W-1] ? (-dividend) : dividend;
  assign dvs_mag_in = divisor[W-1]  ? (-divisor)  : divisor;

  fip_div_step #(
    .W (W)
  ) u_step (
    .rem_in  (rem),
    .num_bit (work[ITER-1]),
    .divisor (dvs_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Final raw quotient including this cycle's bit, rounded if enabled,
  // then signed and saturated to the format limits.
  always_comb begin
    raw_q = {work[ITER-2:0], step_q};
`ifdef FIP_DIV_ROUND_EN
    mag = MAG_W'(raw_q[ITER-1:1]) + MAG_W'(raw_q[0]);
`else
    mag = MAG_W'(raw_q);
`endif
    calc_q   = mag[W-1:0];
    calc_ovf = 1'b0;
    if (!neg) begin
      if (mag > POS_LIM) begin
        calc_q   = Q_MAX;
        calc_ovf = 1'b1;
      end
    end else if (mag > NEG_LIM) begin
      calc_q   = Q_MIN;
      calc_ovf = 1'b1;
    end else begin
      calc_q = -mag[W-1:0];
    end
  end

  // Operand capture on accept and one restoring step per CALC cycle.
  // NOTE: these datapath registers have no reset: they are always loaded
  // on accept before being read, and the FSM alone decides validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      work    <= {dvd_mag_in, {(ITER-W){1'b0}}};
      rem     <= '0;
      dvs_mag <= dvs_mag_in;
      neg     <= dividend[W-1] ^ divisor[W-1];
    end else if (state == CALC) begin
      work <= {work[ITER-2:0], step_q};
      rem  <= step_rem;
    end
  end

  // Control FSM with registered result and handshake outputs.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= dividend[W-1] ? Q_MIN : Q_MAX;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else begin
              state   <= CALC;
              counter <= CNT_LAST;
            end
          end
        end
        CALC: begin
          if (counter == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= calc_q;
            div_by_zero <= 1'b0;
            overflow    <= calc_ovf;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fip_seq_div.sv
// Testbench: tb_fip_seq_div
// Directed table of operand/result vectors for fip_seq_div (Q16.16), plus
// hand-written sequences for output stall, reset mid-operation and
// back-to-back operations with random stalls against a reference model.
module tb_fip_seq_div;
  import fip_pkg::*;

  localparam int W = 32;
`ifdef FIP_DIV_ROUND_EN
  localparam int LAT = 50;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 49;
  localparam bit RND = 1'b0;
`endif
  localparam int BOUND = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic         div_by_zero;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fip_seq_div dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         dbz;
    logic         ovf;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: 64-bit integer divide of |a|<<16 by |b|, then sign/saturate.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned na;
    longint unsigned nb;
    longint unsigned q;
    logic            neg;
    logic [W-1:0]    r;
    if (b == '0) return {1'b1, 1'b0, (a[W-1] ? FIP_MIN : FIP_MAX)};
    na  = {32'd0, (a[W-1] ? (~a + 32'd1) : a)};
    nb  = {32'd0, (b[W-1] ? (~b + 32'd1) : b)};
    neg = a[W-1] ^ b[W-1];
    if (RND) begin
      q = (na << 17) / nb;
      q = (q >> 1) + (q & 64'd1);
    end else begin
      q = (na << 16) / nb;
    end
    if (!neg && q > 64'h7FFF_FFFF) return {2'b01, FIP_MAX};
    if (neg && q > 64'h8000_0000) return {2'b01, FIP_MIN};
    r = q[W-1:0];
    if (neg) r = ~r + 32'd1;
    return {2'b00, r};
  endfunction

  // Issue one operation, measure latency from the accept edge, hold the
  // result for 'stall' cycles, then take it.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                       output logic [W-1:0] q, output logic dbz, output logic ovf,
                       output int lat);
    int n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < BOUND);
    q   = quotient;
    dbz = div_by_zero;
    ovf = overflow;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q;
    logic         dbz;
    logic         ovf;
    int           lat;
    logic [W+1:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0]  = '{32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, LAT, "six_by_two"};
    vecs[1]  = '{32'h0002_0000, 32'h0003_0000, (RND ? 32'h0000_AAAB : 32'h0000_AAAA),
                 1'b0, 1'b0, LAT, "two_by_three"};
    vecs[2]  = '{32'hFFF8_8000, 32'h0002_0000, 32'hFFFC_4000, 1'b0, 1'b0, LAT, "neg7p5_by_two"};
    vecs[3]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, LAT, "min_by_one"};
    vecs[4]  = '{32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, "pos_by_zero"};
    vecs[5]  = '{32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1, "neg_by_zero"};
    vecs[6]  = '{32'h4000_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 1'b1, LAT, "pos_overflow"};
    vecs[7]  = '{32'h0000_0000, 32'hFFFD_0000, 32'h0000_0000, 1'b0, 1'b0, LAT, "zero_by_neg"};
    vecs[8]  = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, LAT, "neg1_by_three"};
    vecs[9]  = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, LAT, "min_by_neg1"};
    vecs[10] = '{32'h0000_0001, 32'h0002_0000, (RND ? 32'h0000_0001 : 32'h0000_0000),
                 1'b0, 1'b0, LAT, "half_ulp_pos"};
    vecs[11] = '{32'hFFFF_FFFF, 32'h0002_0000, (RND ? 32'hFFFF_FFFF : 32'h0000_0000),
                 1'b0, 1'b0, LAT, "half_ulp_neg"};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("ready_in_reset", in_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_quotient", quotient, 32'h0);
    check("rst_div_by_zero", div_by_zero, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, 0, q, dbz, ovf, lat);
      check({vecs[i].name, "_quotient"}, q, vecs[i].q);
      check({vecs[i].name, "_div_by_zero"}, dbz, vecs[i].dbz);
      check({vecs[i].name, "_overflow"}, ovf, vecs[i].ovf);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      @(negedge clk);
      check({vecs[i].name, "_valid_drop"}, out_valid, 1'b0);
      check({vecs[i].name, "_ready_back"}, in_ready, 1'b1);
    end

    // Consumer stall: result and flags hold, no new op accepted.
    @(negedge clk);
    dividend = 32'h0002_0000;
    divisor  = 32'h0003_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < BOUND);
    check("stall_latency", lat, LAT);
    dividend = 32'h0005_0000;
    divisor  = 32'h0000_0000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_quotient", quotient, vecs[1].q);
      check("stall_flags", {div_by_zero, overflow}, 2'b00);
      check("stall_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("stall_valid_drop", out_valid, 1'b0);
    check("stall_quotient_kept", quotient, vecs[1].q);

    // Reset pulsed during CALC: result discarded, block ready again.
    @(negedge clk);
    dividend = 32'h0006_0000;
    divisor  = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_quotient", quotient, 32'h0);
    repeat (LAT) @(negedge clk);
    check("abort_no_late_result", out_valid, 1'b0);
    do_op(32'h0006_0000, 32'h0002_0000, 0, q, dbz, ovf, lat);
    check("after_abort_quotient", q, 32'h0003_0000);
    check("after_abort_latency", lat, LAT);

    // Back-to-back operations with random stalls against the model.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) rb = {{12{rb[31]}}, rb[31:12]};
      if (i == 7) rb = '0;
      exp = model(ra, rb);
      do_op(ra, rb, $urandom_range(0, 3), q, dbz, ovf, lat);
      check("rand_quotient", q, exp[W-1:0]);
      check("rand_flags", {dbz, ovf}, exp[W+1:W]);
      check("rand_latency", lat, (rb == '0) ? 1 : LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
